// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the RISC-V vector bitwise logic unit.
// The XOR datapath exists only when RISCV_V_BW_XOR_EN is defined.
package riscv_v_pkg;

    typedef enum logic [1:0] {
        BW_AND  = 2'd0,
        BW_OR   = 2'd1,
        BW_XOR  = 2'd2,
        BW_RSVD = 2'd3
    } bw_op_e;

    localparam logic [1:0] OSIZE_BYTE  = 2'd0;
    localparam logic [1:0] OSIZE_HALF  = 2'd1;
    localparam logic [1:0] OSIZE_WORD  = 2'd2;
    localparam logic [1:0] OSIZE_DWORD = 2'd3;

    localparam int RISCV_V_BW_MAX_BEATS = 8;

    // Padding byte that leaves a reduction unchanged.
    function automatic logic [7:0] bw_identity(bw_op_e op);
        return (op == BW_AND) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic bw_op_legal(bw_op_e op);
`ifdef RISCV_V_BW_XOR_EN
        return (op == BW_AND) || (op == BW_OR) || (op == BW_XOR);
`else
        return (op == BW_AND) || (op == BW_OR);
`endif
    endfunction

    // Illegal ops yield zero, which is exactly the required result data.
    function automatic logic [63:0] bw_apply64(bw_op_e op, logic [63:0] a, logic [63:0] b);
        case (op)
            BW_AND:  return a & b;
            BW_OR:   return a | b;
`ifdef RISCV_V_BW_XOR_EN
            BW_XOR:  return a ^ b;
`endif
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] osize_mask(logic [1:0] osize);
        case (osize)
            OSIZE_BYTE: return 64'h0000_0000_0000_00FF;
            OSIZE_HALF: return 64'h0000_0000_0000_FFFF;
            OSIZE_WORD: return 64'h0000_0000_FFFF_FFFF;
            default:    return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/riscv_v_bw_tree_reduce.sv
// Combinational halving tree: folds a byte vector down to one osize element.
// XOR folding is present only when RISCV_V_BW_XOR_EN is defined.
module riscv_v_bw_tree_reduce
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  bw_op_e                op,
    input  logic [1:0]            osize,
    output logic [63:0]           result
);

    localparam int LEVELS = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] v;
    int                    elem_bits;

    // Each level folds the upper half onto the lower half; only the low
    // half is meaningful afterwards, so stray upper bits are harmless.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        v         = data;
        elem_bits = 8 << osize;
        for (int l = 0; l < LEVELS; l++) begin
            if ((DATA_WIDTH >> (l + 1)) >= elem_bits) begin
                case (op)
                    BW_AND:  v = v & (v >> (DATA_WIDTH >> (l + 1)));
                    BW_OR:   v = v | (v >> (DATA_WIDTH >> (l + 1)));
`ifdef RISCV_V_BW_XOR_EN
                    BW_XOR:  v = v ^ (v >> (DATA_WIDTH >> (l + 1)));
`endif
                    default: v = v;
                endcase
            end
        end
    end

    assign result = v[63:0] & osize_mask(osize);

    generate
        if (DATA_WIDTH > 64) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^v[DATA_WIDTH-1:64];
        end
    endgenerate

endmodule

// File: rtl/riscv_v_bw_logic_seq.sv
// Vector bitwise logic unit: element-wise AND/OR/XOR and multi-beat reductions.
// XOR support is built only when RISCV_V_BW_XOR_EN is defined.
module riscv_v_bw_logic_seq
    import riscv_v_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    parameter  int MAX_BEATS  = RISCV_V_BW_MAX_BEATS,
    localparam int NUM_BYTES  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic                  is_reduct,
    input  logic [1:0]            osize,
    input  logic                  first,
    input  logic                  last,
    input  logic [DATA_WIDTH-1:0] srca_data,
    input  logic [DATA_WIDTH-1:0] srcb_data,
    input  logic [NUM_BYTES-1:0]  srcb_bvalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_BYTES-1:0]  out_bvalid,
    output logic                  op_err
);

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]       state, state_d;
    logic [63:0]      acc;
    bw_op_e           acc_op;
    logic [1:0]       acc_osize;
    logic [CNT_W-1:0] beat_cnt;

    bw_op_e                op_in, eff_op;
    logic [1:0]            eff_osize;
    logic                  accept, red_first, red_done, acc_we, out_we;
    logic [DATA_WIDTH-1:0] masked_b, ew_data, out_data_d;
    logic [NUM_BYTES-1:0]  red_bvalid, out_bvalid_d;
    logic                  op_err_d;
    logic [63:0]           tree_res, acc_new;
    logic [CNT_W-1:0]      cnt_new;

    assign op_in     = bw_op_e'(op);
    assign out_valid = (state == S_OUT);
    assign in_ready  = (state != S_OUT) | out_ready;
    assign accept    = in_valid & in_ready;

    // A first beat samples op/osize; later beats reuse the captured values.
    assign red_first = is_reduct & first;
    assign eff_op    = red_first ? op_in : acc_op;
    assign eff_osize = red_first ? osize : acc_osize;

    always_comb begin
        masked_b   = '0;
        red_bvalid = '0;
        ew_data    = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            masked_b[b*8 +: 8] = srcb_bvalid[b] ? srcb_data[b*8 +: 8] : bw_identity(eff_op);
            red_bvalid[b]      = (b < (1 << eff_osize));
        end
        for (int c = 0; c < DATA_WIDTH / 64; c++) begin
            ew_data[c*64 +: 64] = bw_apply64(op_in, srca_data[c*64 +: 64], srcb_data[c*64 +: 64]);
        end
    end

    riscv_v_bw_tree_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_tree (
        .data   (masked_b),
        .op     (eff_op),
        .osize  (eff_osize),
        .result (tree_res)
    );

    assign acc_new  = bw_apply64(eff_op,
                                 red_first ? (srca_data[63:0] & osize_mask(eff_osize)) : acc,
                                 tree_res);
    assign cnt_new  = red_first ? CNT_W'(1) : beat_cnt + CNT_W'(1);
    assign red_done = last | (cnt_new == CNT_W'(MAX_BEATS));

    always_comb begin
        state_d      = state;
        acc_we       = 1'b0;
        out_we       = 1'b0;
        out_data_d   = ew_data;
        out_bvalid_d = srcb_bvalid;
        op_err_d     = ~bw_op_legal(op_in);
        if (state == S_OUT && out_ready) state_d = S_IDLE;
        if (accept) begin
            if (!is_reduct) begin
                state_d = S_OUT;
                out_we  = 1'b1;
            end else if (first || state == S_ACCUM) begin
                acc_we = 1'b1;
                if (red_done) begin
                    state_d      = S_OUT;
                    out_we       = 1'b1;
                    out_data_d   = {{(DATA_WIDTH-64){1'b0}}, acc_new};
                    out_bvalid_d = red_bvalid;
                    op_err_d     = ~bw_op_legal(eff_op);
                end else begin
                    state_d = S_ACCUM;
                end
            end
            // A reduct beat without first outside ACCUM is silently dropped.
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc        <= '0;
            acc_op     <= BW_AND;
            acc_osize  <= OSIZE_BYTE;
            beat_cnt   <= '0;
            out_data   <= '0;
            out_bvalid <= '0;
            op_err     <= 1'b0;
        end else begin
            state <= state_d;
            if (acc_we) begin
                acc       <= acc_new;
                acc_op    <= eff_op;
                acc_osize <= eff_osize;
                beat_cnt  <= cnt_new;
            end
            if (out_we) begin
                out_data   <= out_data_d;
                out_bvalid <= out_bvalid_d;
                op_err     <= op_err_d;
            end
        end
    end

endmodule

// File: tb/tb_riscv_v_bw_logic_seq.sv
// Self-checking bench for riscv_v_bw_logic_seq (honours RISCV_V_BW_XOR_EN).
module tb_riscv_v_bw_logic_seq;

`ifdef RISCV_V_BW_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, is_reduct, first, last;
    logic [1:0]   op, osize;
    logic [127:0] srca_data, srcb_data, out_data;
    logic [15:0]  srcb_bvalid, out_bvalid;
    logic         out_valid, out_ready, op_err;

    riscv_v_bw_logic_seq #(.DATA_WIDTH(128), .MAX_BEATS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_reduct(is_reduct), .osize(osize), .first(first), .last(last),
        .srca_data(srca_data), .srcb_data(srcb_data), .srcb_bvalid(srcb_bvalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bvalid(out_bvalid), .op_err(op_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] red_b[$];
    logic [15:0]  red_bv[$];

    typedef struct {
        logic [1:0]   op;
        logic [127:0] a;
        logic [127:0] b;
        logic [15:0]  bv;
        logic [127:0] exp_d;
        logic         exp_e;
    } ew_vec_t;

    ew_vec_t tbl[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic legal(int o);
        return (o == 0) || (o == 1) || (o == 2 && XOR_EN);
    endfunction

    function automatic logic [63:0] comb(int o, logic [63:0] x, logic [63:0] y);
        case (o)
            0:       return x & y;
            1:       return x | y;
            default: return x ^ y;
        endcase
    endfunction

    function automatic logic [127:0] ref_elem(int o, logic [127:0] a, logic [127:0] b);
        logic [127:0] d;
        d[63:0]   = comb(o, a[63:0], b[63:0]);
        d[127:64] = comb(o, a[127:64], b[127:64]);
        return legal(o) ? d : 128'd0;
    endfunction

    // Sequential fold over every element of every queued beat.
    task automatic ref_red(input int o, input int s, input logic [127:0] a,
                           output logic [127:0] d, output logic [15:0] bv, output logic e);
        int          eb;
        logic [63:0] mask, acc, elem;
        logic [7:0]  byte_v;
        eb   = 1 << s;
        mask = (s == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * eb)) - 64'd1);
        acc  = a[63:0] & mask;
        for (int k = 0; k < red_b.size(); k++) begin
            for (int el = 0; el < 16 / eb; el++) begin
                elem = '0;
                for (int j = 0; j < eb; j++) begin
                    byte_v = red_bv[k][el*eb + j] ? red_b[k][(el*eb + j)*8 +: 8]
                                                   : ((o == 0) ? 8'hFF : 8'h00);
                    elem = elem | (64'(byte_v) << (8 * j));
                end
                acc = comb(o, acc, elem);
            end
        end
        e  = ~legal(o);
        d  = e ? 128'd0 : {64'd0, acc};
        bv = 16'((17'd1 << eb) - 17'd1);
    endtask

    task automatic do_beat(input int o, input logic r, input int s, input logic f, input logic l,
                           input logic [127:0] a, input logic [127:0] b, input logic [15:0] bv);
        int waited;
        op = 2'(o); is_reduct = r; osize = 2'(s); first = f; last = l;
        srca_data = a; srcb_data = b; srcb_bvalid = bv; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("accept timeout in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [127:0] d, input logic [15:0] bv, input logic e);
        int waited;
        waited = 0;
        while (!out_valid && waited < 4) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "/valid"}, out_valid, 1);
        check({name, "/data"}, out_data, d);
        check({name, "/bvalid"}, out_bvalid, bv);
        check({name, "/err"}, op_err, e);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ed, a;
        logic [15:0]  ebv;
        logic         ee;
        int           o, s, n;
        logic         l;

        tbl[0] = '{1, {16{8'h0F}}, {16{8'hF0}}, 16'hFFFF, {16{8'hFF}}, 1'b0};
        tbl[1] = '{0, {4{32'hFF00FF00}}, {4{32'h0FF00FF0}}, 16'h00FF, {4{32'h0F000F00}}, 1'b0};
        tbl[2] = '{1, 128'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h1234,
                   128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0};
        tbl[3] = '{2, {4{32'hAAAA5555}}, {4{32'hFFFF0000}},
                   16'hFFFF, XOR_EN ? {4{32'h55555555}} : 128'd0, !XOR_EN};
        tbl[4] = '{3, {16{8'hFF}}, {16{8'hFF}}, 16'hFFFF, 128'd0, 1'b1};
        tbl[5] = '{0, {16{8'hFF}}, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 16'hF0F0,
                   128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; is_reduct = 1'b0; osize = '0; first = 1'b0; last = 1'b0;
        srca_data = '0; srcb_data = '0; srcb_bvalid = '0;
        #12;
        check("reset/out_valid", out_valid, 0);
        check("reset/in_ready", in_ready, 1);
        check("reset/out_data", out_data, 0);
        check("reset/out_bvalid", out_bvalid, 0);
        check("reset/op_err", op_err, 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_beat(tbl[i].op, 1'b0, 0, 1'b0, 1'b0, tbl[i].a, tbl[i].b, tbl[i].bv);
            check_out($sformatf("ew%0d", i), tbl[i].exp_d, tbl[i].bv, tbl[i].exp_e);
        end

        // 2-beat vredand, byte elements, one invalid byte on beat 1.
        do_beat(0, 1'b1, 0, 1'b1, 1'b0, 128'hFF, {16{8'hFE}}, 16'hFFFF);
        check("redand/mid_valid", out_valid, 0);
        do_beat(0, 1'b1, 0, 1'b0, 1'b1, 128'h0, {{12{8'hFF}}, 8'h00, {3{8'hFF}}}, 16'hFFF7);
        check_out("redand", 128'hFE, 16'h0001, 1'b0);

        // Single-beat vredor on words.
        do_beat(1, 1'b1, 2, 1'b1, 1'b1, 128'h1,
                {32'h0004_0000, 32'h0000_3000, 32'h0000_0200, 32'h0000_0010}, 16'hFFFF);
        check_out("redor", 128'h43211, 16'h000F, 1'b0);

        // Backpressure: result held while out_ready=0, drain and accept coincide.
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_beat(1, 1'b0, 0, 1'b0, 1'b0, {16{8'h0F}}, {16{8'hF0}}, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            check("bp/in_ready", in_ready, 0);
            check("bp/out_valid", out_valid, 1);
            check("bp/out_data", out_data, {16{8'hFF}});
            @(posedge clk); #1;
        end
        op = 2'd0; is_reduct = 1'b0; srca_data = {8{16'h1234}}; srcb_data = {16{8'h0F}};
        srcb_bvalid = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp/in_ready_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_out("bp/next", {8{16'h0204}}, 16'h0F0F, 1'b0);
        @(posedge clk); #1;
        check("bp/drained", out_valid, 0);

        // Reduct beat without first while idle is dropped.
        do_beat(1, 1'b1, 0, 1'b0, 1'b1, rnd128(), rnd128(), 16'hFFFF);
        check("drop/out_valid", out_valid, 0);
        check("drop/in_ready", in_ready, 1);

        // Overflow: 8 beats without last end the reduction.
        red_b.delete(); red_bv.delete();
        a = rnd128();
        for (int k = 0; k < 8; k++) begin
            red_b.push_back(rnd128());
            red_bv.push_back(16'($urandom));
            do_beat((k == 0) ? 1 : 0, 1'b1, (k == 0) ? 1 : 3, k == 0, 1'b0, a, red_b[k], red_bv[k]);
            if (k < 7) check($sformatf("ovf/mid%0d", k), out_valid, 0);
        end
        ref_red(1, 1, a, ed, ebv, ee);
        check_out("overflow", ed, ebv, ee);

        // Restart: a second first beat discards the earlier accumulation.
        do_beat(1, 1'b1, 1, 1'b1, 1'b0, rnd128(), rnd128(), 16'hFFFF);
        do_beat(1, 1'b1, 1, 1'b0, 1'b0, rnd128(), rnd128(), 16'hFFFF);
        red_b.delete(); red_bv.delete();
        a = rnd128();
        red_b.push_back(rnd128()); red_bv.push_back(16'hFFFF);
        red_b.push_back(rnd128()); red_bv.push_back(16'hBFFD);
        do_beat(0, 1'b1, 0, 1'b1, 1'b0, a, red_b[0], red_bv[0]);
        check("restart/mid_valid", out_valid, 0);
        do_beat(1, 1'b1, 2, 1'b0, 1'b1, rnd128(), red_b[1], red_bv[1]);
        ref_red(0, 0, a, ed, ebv, ee);
        check_out("restart", ed, ebv, ee);
        @(posedge clk); #1;

        // Reset after beat 2 of 4.
        do_beat(1, 1'b1, 0, 1'b1, 1'b0, rnd128(), rnd128(), 16'hFFFF);
        do_beat(1, 1'b1, 0, 1'b0, 1'b0, rnd128(), rnd128(), 16'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/out_valid", out_valid, 0);
        check("rst_mid/in_ready", in_ready, 1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        do_beat(1, 1'b1, 0, 1'b0, 1'b1, rnd128(), rnd128(), 16'hFFFF);
        check("rst_mid/no_resume", out_valid, 0);

        // Reset while a result is stalled clears it asynchronously.
        out_ready = 1'b0;
        do_beat(1, 1'b0, 0, 1'b0, 1'b0, {16{8'h5A}}, {16{8'hA5}}, 16'hFFFF);
        check("rst_out/pre_valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_out/out_valid", out_valid, 0);
        check("rst_out/out_data", out_data, 0);
        check("rst_out/out_bvalid", out_bvalid, 0);
        out_ready = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        red_b.delete(); red_bv.delete();
        a = rnd128();
        red_b.push_back(rnd128()); red_bv.push_back(16'h7FFF);
        do_beat(0, 1'b1, 3, 1'b1, 1'b1, a, red_b[0], red_bv[0]);
        ref_red(0, 3, a, ed, ebv, ee);
        check_out("rst/fresh", ed, ebv, ee);

        // Randomised mix of element-wise beats and reductions.
        for (int t = 0; t < 40; t++) begin
            o = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                a = rnd128();
                ed = rnd128();
                ebv = 16'($urandom);
                do_beat(o, 1'b0, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), a, ed, ebv);
                check_out($sformatf("rnd%0d/ew", t), ref_elem(o, a, ed), ebv, ~legal(o));
            end else begin
                s = int'($urandom_range(0, 3));
                n = int'($urandom_range(1, 8));
                a = rnd128();
                red_b.delete(); red_bv.delete();
                for (int k = 0; k < n; k++) begin
                    red_b.push_back(rnd128());
                    red_bv.push_back(($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom));
                    l = (k == n - 1) ? ((n == 8) ? 1'($urandom) : 1'b1) : 1'b0;
                    do_beat((k == 0) ? o : int'($urandom_range(0, 3)), 1'b1,
                            (k == 0) ? s : int'($urandom_range(0, 3)), k == 0, l,
                            (k == 0) ? a : rnd128(), red_b[k], red_bv[k]);
                end
                ref_red(o, s, a, ed, ebv, ee);
                check_out($sformatf("rnd%0d/red%0d", t, n), ed, ebv, ee);
            end
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_v_bw_logic_seq.md
# riscv_v_bw_logic_seq

Pipelined, parametrised bitwise logic unit for the RISC-V vector ALU. It executes element-wise AND/OR/XOR (vand/vor/vxor) and multi-beat reductions (vredand/vredor/vredxor) across up to MAX_BEATS register groups (LMUL>1). Reductions accumulate across beats with valid/ready handshakes on both sides. It sits in the vector execute stage between operand read and the writeback arbiter.

## Interface
- DATA_WIDTH, 128: vector datapath width in bits; multiple of 64.
- MAX_BEATS, 8: maximum beats per reduction (LMUL 8).
- NUM_BYTES, DATA_WIDTH/8: derived, not overridable.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- op  in  2  bw_op_e: 0 AND, 1 OR, 2 XOR, 3 reserved.
- is_reduct  in  1  reduction beat.
- osize  in  2  element size: 0 byte, 1 half, 2 word, 3 dword.
- first, last  in  1 each  reduction beat markers; ignored when is_reduct=0.
- srca_data, srcb_data  in  DATA_WIDTH  operands (srca = vs1, srcb = vs2).
- srcb_bvalid  in  NUM_BYTES  per-byte valid of srcb (tail/mask).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  result.
- out_bvalid  out  NUM_BYTES  per-byte valid of out_data.
- op_err  out  1  op was illegal for this build; qualified by out_valid.

## Operation
- Element-wise (is_reduct=0): out_data = srca op srcb per byte. out_bvalid = srcb_bvalid.
- Reduction: invalid srcb bytes are replaced by the identity (0x00 for OR/XOR, 0xFF for AND). The beat is then tree-reduced to one osize element.
- On the first beat, acc = srca element 0 op tree result. On later beats, acc = acc op tree result.
- On the last beat, out_data[osize bits] = the final acc, upper bytes = 0. out_bvalid = 1 for the low 2^osize bytes only.
- FSM states:
  - IDLE: an accepted reduct beat with first goes to ACCUM, or to OUT if last is also set. An accepted element-wise beat goes to OUT. A reduct beat without first is dropped; in_ready stays 1.
  - ACCUM: an accepted beat with last goes to OUT. A beat with first restarts the accumulation from that beat and discards the old acc.
  - OUT: out_valid=1; out_valid&out_ready goes to IDLE.
- Beat counter, width $clog2(MAX_BEATS)+1: cleared on first and incremented per accepted reduct beat. If the count reaches MAX_BEATS without last, that beat is treated as last.
- op and osize are sampled on first. Mid-reduction changes are ignored.
- op=3 is illegal: out_data=0, op_err=1, and an element-wise/last beat goes to OUT as normal.

## Timing
- Reset values: out_valid=0, out_data=0, out_bvalid=0, op_err=0, state=IDLE, acc=0, beat counter=0. in_ready=1 after reset.
- Element-wise latency is 1 cycle: a beat accepted at edge N gives out_valid from edge N to N+1.
- Reduction latency: out_valid rises 1 cycle after the last beat is accepted.
- in_ready = (state!=OUT) | out_ready. With out_ready=1 the unit takes one beat per cycle back-to-back, with no bubble.
- While out_valid=1 and out_ready=0, out_data/out_bvalid/op_err hold stable.
- rst_n assertion mid-reduction discards acc and clears out_valid immediately (async). The interrupted reduction is not resumed.

## Configuration
- RISCV_V_BW_XOR_EN defined: the XOR datapath and vredxor are built, and op=2 is legal.
- Not defined: there is no XOR logic, and op=2 is handled exactly as op=3 (out_data=0, op_err=1).

## Structure
- riscv_v_pkg holds:
  - bw_op_e enum;
  - osize encoding constants;
  - RISCV_V_BW_MAX_BEATS default;
  - function bw_identity(op) returning the identity byte.
- One sub-module, riscv_v_bw_tree_reduce: combinational log2(NUM_BYTES)-level tree. It takes a byte vector, op and osize, and returns a 64-bit reduced element zero-extended for smaller osize. Instantiated once.
- The FSM, accumulator, beat counter and output register stay in riscv_v_bw_logic_seq.

## Test plan
- Element-wise OR: srca=0x0F repeated, srcb=0xF0 repeated, srcb_bvalid all 1 -> one cycle later out_data all 0xFF, out_bvalid all 1.
- 2-beat vredand, osize=0: srca byte0=0xFF; beat0 srcb all 0xFE; beat1 srcb all 0xFF with byte3 invalid and =0x00 -> out_data=0x00..00FE, out_bvalid=0x0001.
- Single-beat vredor, osize=2 (first&last): srca word0=0x1; srcb words 0x10,0x200,0x3000,0x40000 -> out_data low word=0x43211, out_bvalid=0x000F.
- Backpressure: hold out_ready=0 for 3 cycles after an element-wise result -> in_ready=0 and out_data stable; out_ready=1 -> drains, and the next beat is accepted in the same cycle.
- Overflow/restart: 8 reduct beats with no last -> output after the 8th beat. A separately issued first mid-ACCUM -> the result reflects only the beats from the restart.
- Reset mid-reduction: rst_n low after beat 2 of 4 -> out_valid=0 immediately; after release, a fresh single-beat reduction gives the correct value. op=2 without RISCV_V_BW_XOR_EN -> out_data=0, op_err=1.
